wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
// - Writer side of the register-file write port: sole driver of rd/datawb/regwren into the register file.
// - Merges two writeback sources: single-cycle ALU results (always accepted, highest priority) and
//   load returns from data memory (valid/ready handshake, buffered in a FIFO).
// - Guarantees at most one register write per cycle, never targets x0, and prevents load starvation
//   by requesting a pipeline stall.
// PARAMETERS
// - DWIDTH        32  writeback data width
// - LQ_DEPTH      4   load-return FIFO entries (power of 2, >=2)
// - STARVE_LIMIT  8   consecutive blocked cycles before stall_o asserts (>=1)
// PORTS
// - clk           in   1        clock; all state updates on posedge
// - rst_n         in   1        asynchronous, active-low reset
// - alu_valid_i   in   1        ALU result valid this cycle (no ready; always accepted)
// - alu_rd_i      in   5        ALU destination register
// - alu_data_i    in   DWIDTH   ALU result
// - ld_valid_i    in   1        load return valid
// - ld_ready_o    out  1        FIFO can accept; equals !full (combinational from count)
// - ld_rd_i       in   5        load destination register
// - ld_data_i     in   DWIDTH   load data
// - rd_o          out  5        register-file write address (registered)
// - datawb_o      out  DWIDTH   register-file write data (registered)
// - regwren_o     out  1        register-file write enable (registered)
// - stall_o       out  1        request upstream to hold ALU issue (registered)
// - lq_count_o    out  $clog2(LQ_DEPTH+1)  FIFO occupancy
// - lq_pending_o  out  32       bit r set while a queued load targets xr (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_n=0, async): rd_o=0, datawb_o=0, regwren_o=0, stall_o=0, FIFO emptied (lq_count_o=0,
//   ld_ready_o=1), starvation counter=0, FSM=NORMAL. Reset mid-operation discards queued loads.
// - Load push: ld_valid_i && ld_ready_o at posedge -> enqueue {rd,data}. No bypass.
// - Selection per cycle (sampled at posedge, outputs valid next cycle):
//   * alu_valid_i=1 -> output ALU result; FIFO head not popped.
//   * else FIFO non-empty -> pop head, output it.
//   * else regwren_o=0; rd_o/datawb_o hold previous values.
// - x0 rule: a selected entry with rd=0 still consumes its slot (ALU dropped / head popped) but
//   regwren_o=0 that cycle.
// - Latency: ALU cycle t -> regwren_o in t+1. Load accepted t -> earliest regwren_o in t+2.
// - Push and pop same cycle: count unchanged; at full ld_ready_o=0 so no push occurs.
// - Pointers wrap modulo LQ_DEPTH; FIFO order strictly preserved.
// - Starvation counter: +1 each cycle with FIFO non-empty and alu_valid_i=1 (head blocked), saturating
//   at STARVE_LIMIT; cleared on any pop or when FIFO empty.
// - FSM NORMAL -> STALL when counter reaches STARVE_LIMIT (stall_o=1 from next cycle).
//   STALL -> NORMAL on the cycle the last entry pops with no push (stall_o=0 next cycle).
// - In STALL upstream must hold alu_valid_i=0; if violated ALU still wins (bench asserts this).
// CONFIGURATION
// - Macro WB_PENDING_EN defined: lq_pending_o = OR over valid FIFO entries of onehot(rd), bit 0
//   forced 0; combinational from FIFO state, updates same cycle as push/pop takes effect.
// - WB_PENDING_EN undefined: lq_pending_o tied to 32'h0, no per-entry decode logic.
// TESTING
// - Reset: hold rst_n=0 -> regwren_o=0, rd_o=0, datawb_o=0, stall_o=0, ld_ready_o=1, lq_count_o=0.
// - ALU write: alu_valid_i=1, rd=5, data=32'hDEADBEEF at t -> t+1: regwren_o=1, rd_o=5, datawb_o=DEADBEEF.
// - x0 drop: ALU rd=0 data=32'h1 and load rd=0 -> regwren_o never 1; load slot freed (count back to 0).
// - Load path: ALU idle, load rd=7 data=32'h1234 at t -> lq_count_o=1 at t+1, regwren_o=1 rd_o=7 at t+2.
// - Full/starve: ALU valid continuously, push 4 loads -> ld_ready_o=0 at count 4; after 8 blocked
//   cycles stall_o=1; drop ALU -> 4 writes in order on consecutive cycles, stall_o=0 after last.
// - WB_PENDING_EN: queue loads rd=9, rd=9, rd=3 -> lq_pending_o=32'h208; after first pop still 32'h208,
//   after second 32'h8, after third 0. Without macro: always 0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU results win, load returns queue in a FIFO.
// Optional WB_PENDING_EN exposes a per-register mask of queued load targets.
module wb_write_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid_i,
  input  logic [4:0]                    alu_rd_i,
  input  logic [DWIDTH-1:0]             alu_data_i,
  input  logic                          ld_valid_i,
  output logic                          ld_ready_o,
  input  logic [4:0]                    ld_rd_i,
  input  logic [DWIDTH-1:0]             ld_data_i,
  output logic [4:0]                    rd_o,
  output logic [DWIDTH-1:0]             datawb_o,
  output logic                          regwren_o,
  output logic                          stall_o,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count_o,
  output logic [31:0]                   lq_pending_o
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  typedef enum logic {NORMAL, STALL} state_e;

  logic [4:0]        mem_rd_q   [LQ_DEPTH];
  logic [4:0]        mem_rd_d   [LQ_DEPTH];
  logic [DWIDTH-1:0] mem_data_q [LQ_DEPTH];
  logic [DWIDTH-1:0] mem_data_d [LQ_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  state_e            state_q, state_d;
  logic              full, push, pop;

  assign full       = (cnt_q == CW'(LQ_DEPTH));
  assign ld_ready_o = !full;
  assign push       = ld_valid_i && !full;
  assign pop        = !alu_valid_i && (cnt_q != '0);
  assign lq_count_o = cnt_q;
  assign rd_o       = rd_q;
  assign datawb_o   = data_q;
  assign regwren_o  = wren_q;

  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_rd_d[wptr_q]   = ld_rd_i;
      mem_data_d[wptr_q] = ld_data_i;
    end
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    wren_d = 1'b0;
    unique case (1'b1)
      alu_valid_i: begin
        rd_d   = alu_rd_i;
        data_d = alu_data_i;
        wren_d = (alu_rd_i != 5'd0);
      end
      pop: begin
        rd_d   = mem_rd_q[rptr_q];
        data_d = mem_data_q[rptr_q];
        wren_d = (mem_rd_q[rptr_q] != 5'd0);
      end
      default: ;
    endcase
  end

  // Head is blocked only while the ALU owns the port and something waits.
  always_comb begin
    starve_d = starve_q;
    if (cnt_q == '0 || pop)
      starve_d = '0;
    else if (alu_valid_i && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: if (starve_d == SW'(STARVE_LIMIT)) state_d = STALL;
      STALL:  if (pop && cnt_q == CW'(1) && !push) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    stall_o = (state_q == STALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      state_q  <= NORMAL;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      state_q    <= state_d;
    end
  end

`ifdef WB_PENDING_EN
  logic [31:0]   pend;
  logic [PW-1:0] idx;
  always_comb begin
    pend = '0;
    idx  = '0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if (CW'(k) < cnt_q) pend[mem_rd_q[idx]] = 1'b1;
    end
    pend[0] = 1'b0;
  end
  assign lq_pending_o = pend;
`else
  assign lq_pending_o = 32'h0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a write scoreboard.
// Define WB_PENDING_EN to check the pending mask.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o;
  logic        stall_o;
  logic [2:0]  lq_count_o;
  logic [31:0] lq_pending_o;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i),
    .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .rd_o(rd_o), .datawb_o(datawb_o),
    .regwren_o(regwren_o), .stall_o(stall_o),
    .lq_count_o(lq_count_o), .lq_pending_o(lq_pending_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pend(input string tag, input logic [31:0] exp);
`ifdef WB_PENDING_EN
    chk(tag, lq_pending_o, exp);
`else
    chk(tag, lq_pending_o, 32'h0);
`endif
  endtask

  // Advance one edge; compare any register write to the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    @(negedge clk);
    if (regwren_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_rd", {27'd0, rd_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_rd", {27'd0, rd_o}, {27'd0, e[36:32]});
        chk("sb_data", datawb_o, e[31:0]);
      end
    end
  endtask

  task automatic idle();
    alu_valid_i = 1'b0;
    alu_rd_i    = '0;
    alu_data_i  = '0;
    ld_valid_i  = 1'b0;
    ld_rd_i     = '0;
    ld_data_i   = '0;
  endtask

  task automatic load(input logic [4:0] r, input logic [31:0] d,
                      input bit track);
    ld_valid_i = 1'b1;
    ld_rd_i    = r;
    ld_data_i  = d;
    if (track && r != 0) sb.push_back({r, d});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_regwren", {31'd0, regwren_o}, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_data", datawb_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_ready", {31'd0, ld_ready_o}, 32'd1);
    chk("rst_count", {29'd0, lq_count_o}, 32'd0);
    chk_pend("rst_pend", 32'h0);
    rst_n = 1'b1;
    tick();

    // ALU write
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd5;
    alu_data_i  = 32'hDEADBEEF;
    sb.push_back({5'd5, 32'hDEADBEEF});
    tick();
    chk("alu_wren", {31'd0, regwren_o}, 32'd1);
    idle();
    tick();
    chk("alu_idle_wren", {31'd0, regwren_o}, 32'd0);
    chk("alu_hold_rd", {27'd0, rd_o}, 32'd5);
    chk("alu_hold_data", datawb_o, 32'hDEADBEEF);

    // x0 writes are dropped but still consume their slot
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd0;
    alu_data_i  = 32'h1;
    load(5'd0, 32'hAA, 1'b1);
    tick();
    chk("x0_alu_wren", {31'd0, regwren_o}, 32'd0);
    chk("x0_count1", {29'd0, lq_count_o}, 32'd1);
    idle();
    tick();
    chk("x0_ld_wren", {31'd0, regwren_o}, 32'd0);
    chk("x0_count0", {29'd0, lq_count_o}, 32'd0);

    // Load path latency
    load(5'd7, 32'h1234, 1'b1);
    tick();
    idle();
    chk("ld_count", {29'd0, lq_count_o}, 32'd1);
    chk("ld_t1_wren", {31'd0, regwren_o}, 32'd0);
    chk_pend("ld_pend", 32'h80);
    tick();
    chk("ld_t2_wren", {31'd0, regwren_o}, 32'd1);
    chk("ld_t2_count", {29'd0, lq_count_o}, 32'd0);

    // Fill under continuous ALU traffic, then starve
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd0;
    alu_data_i  = 32'h55;
    load(5'd9, 32'h9001, 1'b1);
    tick();
    load(5'd9, 32'h9002, 1'b1);
    tick();
    load(5'd3, 32'h3003, 1'b1);
    tick();
    chk_pend("pend_993", 32'h208);
    load(5'd12, 32'hC004, 1'b1);
    tick();
    ld_valid_i = 1'b0;
    chk("full_count", {29'd0, lq_count_o}, 32'd4);
    chk("full_ready", {31'd0, ld_ready_o}, 32'd0);
    chk_pend("pend_full", 32'h1208);
    repeat (4) tick();
    chk("stall_before", {31'd0, stall_o}, 32'd0);
    tick();
    chk("stall_set", {31'd0, stall_o}, 32'd1);
    tick();
    chk("stall_alu_wins", {29'd0, lq_count_o}, 32'd4);
    alu_valid_i = 1'b0;
    tick();
    chk("drain1_wren", {31'd0, regwren_o}, 32'd1);
    chk("drain1_stall", {31'd0, stall_o}, 32'd1);
    chk("drain1_ready", {31'd0, ld_ready_o}, 32'd1);
    chk_pend("drain1_pend", 32'h1208);
    tick();
    chk("drain2_wren", {31'd0, regwren_o}, 32'd1);
    chk_pend("drain2_pend", 32'h1008);
    tick();
    chk("drain3_wren", {31'd0, regwren_o}, 32'd1);
    chk("drain3_stall", {31'd0, stall_o}, 32'd1);
    chk_pend("drain3_pend", 32'h1000);
    tick();
    chk("drain4_wren", {31'd0, regwren_o}, 32'd1);
    chk("drain4_stall", {31'd0, stall_o}, 32'd0);
    chk("drain4_count", {29'd0, lq_count_o}, 32'd0);
    chk_pend("drain4_pend", 32'h0);
    tick();
    chk("drained_wren", {31'd0, regwren_o}, 32'd0);

    // Asynchronous reset discards queued loads
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd0;
    load(5'd4, 32'h4444, 1'b0);
    tick();
    load(5'd6, 32'h6666, 1'b0);
    tick();
    idle();
    chk("mid_count", {29'd0, lq_count_o}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", {29'd0, lq_count_o}, 32'd0);
    chk("arst_ready", {31'd0, ld_ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("arst_no_wren", {31'd0, regwren_o}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
